// File: rtl/bmu_wb_buffer.sv
// BMU writeback buffer: captures one-cycle-latency BMU results and queues them
// in a first-word-fall-through FIFO for the register-file write port.
module bmu_wb_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     valid_in,
    input  logic [4:0]               rd_in,
    input  logic [31:0]              result_ff,
    input  logic                     error,
    input  logic                     flush_in,
    output logic                     issue_ready,
    output logic                     wb_valid,
    output logic [4:0]               wb_rd,
    output logic [31:0]              wb_data,
    output logic                     wb_error,
    input  logic                     wb_ready,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [7:0]               err_count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned OW    = AW + 1;
    localparam int unsigned SW    = OW + 1;
    localparam int unsigned RD_W  = 5;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned ERR_W = 8;

    typedef struct packed {
        logic [RD_W-1:0]  rd;
        logic [DAT_W-1:0] data;
        logic             err;
    } entry_t;

    logic              pend_v_q, pend_v_d;
    logic [RD_W-1:0]   pend_rd_q, pend_rd_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]     occ_q, occ_d;
    logic [ERR_W-1:0]  err_q, err_d;
    entry_t            mem_q [DEPTH];
    entry_t            head_c;
    logic              push_c;
    logic              pop_c;

    // Handshake decode; issue_ready depends only on registered state.
    always_comb begin
        issue_ready = (SW'(occ_q) + SW'(pend_v_q)) < SW'(DEPTH);
        wb_valid    = (occ_q != '0);
        push_c      = pend_v_q & (pend_rd_q != '0) & ~flush_in;
        pop_c       = wb_valid & wb_ready & ~flush_in;
        head_c      = mem_q[rd_ptr_q];
        wb_rd       = wb_valid ? head_c.rd   : '0;
        wb_data     = wb_valid ? head_c.data : '0;
        wb_error    = wb_valid ? head_c.err  : 1'b0;
        occupancy   = occ_q;
        err_count   = err_q;
    end

    // Next-state for capture stage, pointers, occupancy and error counter.
    always_comb begin
        pend_v_d  = valid_in & issue_ready & ~flush_in;
        pend_rd_d = rd_in;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        err_d     = err_q;
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
            occ_d = occ_q + OW'(push_c) - OW'(pop_c);
            // rd=0 results are dropped but their errors still count.
            if (pend_v_q && error && (err_q != '1)) err_d = err_q + ERR_W'(1);
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            pend_v_q  <= 1'b0;
            pend_rd_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            err_q     <= '0;
        end else begin
            pend_v_q  <= pend_v_d;
            pend_rd_q <= pend_rd_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            err_q     <= err_d;
        end
    end

    // Result storage; not reset, contents are masked by occupancy.
    always_ff @(posedge clk) begin
        if (rst_l && push_c) begin
            mem_q[wr_ptr_q] <= '{rd: pend_rd_q, data: result_ff, err: error};
        end
    end

    // issue_ready flow control must make a push into a full buffer impossible.
    always_ff @(posedge clk) begin
        if (rst_l && push_c) begin
            assert (occ_q < OW'(DEPTH));
        end
    end

endmodule

// File: tb/tb_bmu_wb_buffer.sv
// Directed self-checking bench for bmu_wb_buffer (DEPTH=4).
module tb_bmu_wb_buffer;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        valid_in;
    logic [4:0]  rd_in;
    logic [31:0] result_ff;
    logic        error;
    logic        flush_in;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_error;
    logic        wb_ready;
    logic [2:0]  occupancy;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    bmu_wb_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst_l(rst_l), .valid_in(valid_in), .rd_in(rd_in),
        .result_ff(result_ff), .error(error), .flush_in(flush_in),
        .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_error(wb_error), .wb_ready(wb_ready),
        .occupancy(occupancy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0; rd_in = '0; result_ff = '0; error = 1'b0;
        flush_in = 1'b0; wb_ready = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_l = 1'b0;
        tick(); tick();
        rst_l = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_l = 1'b0;
        tick(); tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %0h expected 0", wb_valid); end
        checks++; if ({wb_rd, wb_data, wb_error} !== 38'h0) begin errors++; $display("FAIL reset_head: got rd=%0h data=%0h err=%0h expected 0", wb_rd, wb_data, wb_error); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %0h expected 1", issue_ready); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err_count); end
        rst_l = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        apply_reset();
        wb_ready = 1'b1;
        valid_in = 1'b1; rd_in = 5'd5;
        tick();
        rd_in = 5'd7; result_ff = 32'h0000_00FF; error = 1'b0;
        tick();
        checks++; if ({wb_valid, wb_rd, wb_data, wb_error} !== {1'b1, 5'd5, 32'hFF, 1'b0}) begin errors++; $display("FAIL basic_head5: got v=%0h rd=%0d data=%0h err=%0h expected v=1 rd=5 data=ff err=0", wb_valid, wb_rd, wb_data, wb_error); end
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL basic_occ1: got %0d expected 1", occupancy); end
        valid_in = 1'b0; result_ff = 32'h0000_1234; error = 1'b1;
        tick();
        checks++; if ({wb_valid, wb_rd, wb_data, wb_error} !== {1'b1, 5'd7, 32'h1234, 1'b1}) begin errors++; $display("FAIL basic_head7: got v=%0h rd=%0d data=%0h err=%0h expected v=1 rd=7 data=1234 err=1", wb_valid, wb_rd, wb_data, wb_error); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL basic_err: got %0d expected 1", err_count); end
        result_ff = '0; error = 1'b0;
        tick();
        checks++; if ({wb_valid, wb_rd, wb_data, wb_error, occupancy} !== 41'h0) begin errors++; $display("FAIL basic_drain: got v=%0h rd=%0d data=%0h err=%0h occ=%0d expected all 0", wb_valid, wb_rd, wb_data, wb_error, occupancy); end
    endtask

    task automatic test_fill();
        logic [5:0]  exp_ready;
        logic [4:0]  prev_rd;
        exp_ready = 6'b001111;   // bit c = issue_ready expected in cycle c
        prev_rd   = '0;
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            valid_in = 1'b1; rd_in = 5'(c + 1);
            result_ff = 32'h100 + 32'(prev_rd); error = 1'b0;
            checks++; if (issue_ready !== exp_ready[c]) begin errors++; $display("FAIL fill_ready_c%0d: got %0h expected %0h", c, issue_ready, exp_ready[c]); end
            prev_rd = rd_in;
            tick();
        end
        valid_in = 1'b0; result_ff = '0;
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL fill_occ4: got %0d expected 4", occupancy); end
        wb_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'(k), 32'h100 + 32'(k)}) begin errors++; $display("FAIL fill_pop%0d: got v=%0h rd=%0d data=%0h expected v=1 rd=%0d data=%0h", k, wb_valid, wb_rd, wb_data, k, 32'h100 + k); end
            tick();
            if (k == 1) begin
                checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after_pop: got %0h expected 1", issue_ready); end
            end
        end
        checks++; if ({wb_valid, occupancy} !== 4'h0) begin errors++; $display("FAIL fill_empty: got v=%0h occ=%0d expected 0", wb_valid, occupancy); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        wb_ready = 1'b1;
        for (int i = 0; i <= 21; i++) begin
            valid_in  = (i < 20);
            rd_in     = 5'(i % 31 + 1);
            result_ff = (i >= 1) ? 32'hA500_0000 + 32'(i - 1) : 32'h0;
            error     = 1'b0;
            if (i >= 2) begin
                checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'((i - 2) % 31 + 1), 32'hA500_0000 + 32'(i - 2)}) begin errors++; $display("FAIL b2b_head_op%0d: got v=%0h rd=%0d data=%0h", i - 2, wb_valid, wb_rd, wb_data); end
            end
            tick();
            if (i >= 1 && i <= 20) begin
                checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL b2b_occ_c%0d: got %0d expected 1", i, occupancy); end
            end
        end
        valid_in = 1'b0; result_ff = '0;
        checks++; if ({wb_valid, occupancy} !== 4'h0) begin errors++; $display("FAIL b2b_empty: got v=%0h occ=%0d expected 0", wb_valid, occupancy); end
    endtask

    task automatic test_rd0_errors();
        apply_reset();
        wb_ready = 1'b1;
        valid_in = 1'b1; rd_in = 5'd0;
        tick();
        valid_in = 1'b0; result_ff = 32'hDEAD_BEEF; error = 1'b1;
        tick();
        checks++; if ({wb_valid, occupancy} !== 4'h0) begin errors++; $display("FAIL rd0_no_push: got v=%0h occ=%0d expected 0", wb_valid, occupancy); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL rd0_err: got %0d expected 1", err_count); end
        for (int j = 0; j < 300; j++) begin
            valid_in = 1'b1; rd_in = 5'd0; error = 1'b1;
            tick();
            if (j == 99) begin
                checks++; if (err_count !== 8'd100) begin errors++; $display("FAIL err_mid: got %0d expected 100", err_count); end
            end
        end
        valid_in = 1'b0;
        tick();
        error = 1'b0;
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL err_sat: got %0d expected 255", err_count); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL err_sat_wb: got %0h expected 0", wb_valid); end
    endtask

    task automatic test_flush();
        apply_reset();
        wb_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            valid_in  = 1'b1; rd_in = 5'(c + 1);
            result_ff = 32'h200 + 32'(c);
            error     = (c == 3);   // result of op3 errors
            tick();
        end
        checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL flush_pre_occ: got %0d expected 3", occupancy); end
        valid_in = 1'b0; flush_in = 1'b1; wb_ready = 1'b1;
        result_ff = 32'h204; error = 1'b1;   // in-flight op4, errored
        tick();
        flush_in = 1'b0; error = 1'b0;
        checks++; if ({wb_valid, occupancy} !== 4'h0) begin errors++; $display("FAIL flush_empty: got v=%0h occ=%0d expected 0", wb_valid, occupancy); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL flush_err: got %0d expected 1", err_count); end
        tick();
        checks++; if ({wb_valid, occupancy, issue_ready} !== 5'b00001) begin errors++; $display("FAIL flush_inflight: got v=%0h occ=%0d rdy=%0h expected 0,0,1", wb_valid, occupancy, issue_ready); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        wb_ready = 1'b0;
        valid_in = 1'b1; rd_in = 5'd9;
        tick();
        rd_in = 5'd10; result_ff = 32'h909; error = 1'b1;
        tick();
        valid_in = 1'b0; result_ff = 32'hA0A; error = 1'b0;
        tick();
        checks++; if ({occupancy, err_count} !== {3'd2, 8'd1}) begin errors++; $display("FAIL rstmid_pre: got occ=%0d err=%0d expected 2,1", occupancy, err_count); end
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1; wb_ready = 1'b1;
        checks++; if ({wb_valid, wb_rd, wb_data, wb_error, occupancy, err_count} !== 49'h0) begin errors++; $display("FAIL rstmid_outs: got v=%0h rd=%0d data=%0h err=%0h occ=%0d cnt=%0d expected 0", wb_valid, wb_rd, wb_data, wb_error, occupancy, err_count); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %0h expected 1", issue_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale_c%0d: got %0h expected 0", c, wb_valid); end
        end
    endtask

    initial begin
        rst_l = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_fill();
        test_back_to_back();
        test_rd0_errors();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bmu_wb_buffer.md
BMU_WB_BUFFER -- requirements
Module: bmu_wb_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of result-buffer entries; power of two, 2..8.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_l  input  1  reset, synchronous, active-low.
REQ-004 valid_in  input  1  operation issued to the BMU this cycle; counted only when issue_ready=1.
REQ-005 rd_in  input  5  destination register of the issued operation.
REQ-006 result_ff  input  32  BMU result, valid one cycle after the issue.
REQ-007 error  input  1  BMU error flag, aligned with result_ff.
REQ-008 flush_in  input  1  discard all pending and buffered results.
REQ-009 issue_ready  output  1  a new BMU issue is accepted this cycle.
REQ-010 wb_valid  output  1  buffer head holds a result for writeback.
REQ-011 wb_rd  output  5  head destination register.
REQ-012 wb_data  output  32  head result.
REQ-013 wb_error  output  1  head error flag.
REQ-014 wb_ready  input  1  register-file write port accepts the head.
REQ-015 occupancy  output  $clog2(DEPTH)+1  number of buffered entries.
REQ-016 err_count  output  8  saturating count of errored results captured.

Function
REQ-017 Capture stage: pend_v <= valid_in & issue_ready & ~flush_in; pend_rd <= rd_in, registered every cycle.
REQ-018 When pend_v=1, push {pend_rd, result_ff, error} in the same cycle; fixed 1-cycle BMU latency.
REQ-019 When pend_rd=0, no push; error, if set, still counts in err_count.
REQ-020 Buffer: FIFO of DEPTH entries, first-word-fall-through; wb_valid = (occupancy != 0).
REQ-021 wb_rd, wb_data and wb_error read 0 whenever wb_valid=0.
REQ-022 Pop when wb_valid & wb_ready; the next entry is presented in the following cycle.
REQ-023 issue_ready = ((occupancy + pend_v) < DEPTH); driven only from registered state, with no path from wb_ready.
REQ-024 Overflow impossible by REQ-023; a push into a full buffer is an assertion failure.
REQ-025 Simultaneous push and pop: occupancy unchanged, order preserved, including the wrap-around of the read and write pointers.
REQ-026 Pop when empty: ignored.
REQ-027 err_count increments by 1 on each captured result with error=1 (pend_v=1), saturating at 255.
REQ-028 flush_in=1: next cycle occupancy=0, pointers=0 and pend_v=0.
REQ-029 flush_in=1: any same-cycle push and pop are dropped; err_count is preserved, and the in-flight result is not counted.
REQ-030 Writeback order equals issue order, excluding results with rd=0 and flushed results.

Reset
REQ-031 rst_l=0 at posedge clk clears pend_v, pointers, occupancy and err_count.
REQ-032 During and after reset: wb_valid=0, wb_rd/wb_data/wb_error=0, issue_ready=1; buffer storage is not cleared.
REQ-033 Reset mid-operation discards all pending and buffered results, with no writeback of them afterwards.
REQ-034 Reset has priority over flush_in, push and pop.

Verification
REQ-035 Basic: wb_ready=1; issue rd=5, then result_ff=0x0000_00FF, error=0 -> wb_valid=1, wb_rd=5, wb_data=0xFF two cycles after issue; occupancy returns to 0.
REQ-036 Fill/backpressure: wb_ready=0; valid_in held for 6 cycles with rd=1..6 -> 4 accepted, issue_ready=0 once occupancy+pend_v=4. Then wb_ready=1 -> wb_rd sequence 1,2,3,4, and issue_ready rises after the first pop.
REQ-037 Wrap plus simultaneous events: continuous issue with wb_ready=1 for 20 ops -> occupancy stays at 1, with in-order data across pointer wrap.
REQ-038 rd=0 and errors: issue rd=0 with error=1 -> no wb_valid, err_count=1. 300 errored ops -> err_count=255.
REQ-039 Flush: 3 entries buffered plus 1 in flight, then flush_in=1 -> next cycle occupancy=0, wb_valid=0, in-flight result absent, err_count unchanged.
REQ-040 Reset mid-stream: rst_l=0 for one cycle with 2 entries buffered -> all outputs 0, issue_ready=1, err_count=0, and no stale writeback afterwards.
